// File: rtl/quiz_host_pkg.sv
// Shared definitions for the quiz host: FSM encoding, score digit width,
// player count and small BCD/priority helpers.
package quiz_host_pkg;

    localparam int DIGIT_W     = 4;
    localparam int NUM_PLAYERS = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_JUDGE = 3'd2,
        ST_NOANS = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef logic [DIGIT_W-1:0] digit_t;

    function automatic digit_t bcd_inc_sat(input digit_t d);
        return (d >= digit_t'(9)) ? digit_t'(9) : d + digit_t'(1);
    endfunction

    function automatic digit_t bcd_dec_sat(input digit_t d);
        return (d == '0) ? '0 : d - digit_t'(1);
    endfunction

    // Lowest set bit wins when several players buzz in the same cycle.
    function automatic logic [1:0] lowest_player(input logic [NUM_PLAYERS-1:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (m[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/quiz_host_key_debounce.sv
// Key conditioner: 2-flop synchronizer, stability counter and a one-cycle
// pulse on each accepted rising edge.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic pulse_o
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q;
    logic [1:0]       vld_q;
    logic             stable_q, stable_d;
    logic             released_q, released_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            vld_q      <= '0;
            stable_q   <= 1'b0;
            released_q <= 1'b0;
            pulse_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync_q     <= {sync_q[0], key_i};
            vld_q      <= {vld_q[0], 1'b1};
            stable_q   <= stable_d;
            released_q <= released_d;
            pulse_q    <= pulse_d;
            cnt_q      <= cnt_d;
        end
    end

    // A key held through reset must be seen low once before it can fire.
    always_comb begin
        stable_d   = stable_q;
        cnt_d      = '0;
        pulse_d    = 1'b0;
        released_d = released_q | (vld_q[1] & ~sync_q[1]);
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q[1];
                pulse_d  = sync_q[1] & released_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/quiz_host.sv
// Quiz host controller: debounced host keys drive a round/judge FSM that
// keeps four BCD scores and reports the round number and winners.
module quiz_host
    import quiz_host_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int MAX_ROUNDS   = 9,
    parameter int WIN_SCORE    = 5
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   Next_Key,
    input  logic                   Correct_Key,
    input  logic                   Wrong_Key,
    input  logic [NUM_PLAYERS-1:0] Player_Number,
    input  logic                   Time_Over,
    output logic                   Start_Out,
    output logic [15:0]            Score_Out,
    output logic [3:0]             Round_Out,
    output logic [NUM_PLAYERS-1:0] Winner_Out,
    output logic                   Game_Over_Out
);

    localparam digit_t     WIN_D = digit_t'(WIN_SCORE);
    localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

    logic [2:0] keys;
    logic [2:0] press;
    assign keys = {Wrong_Key, Correct_Key, Next_Key};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_key
            key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
                .clk_i  (CLK),
                .rst_ni (RSTn),
                .key_i  (keys[gi]),
                .pulse_o(press[gi])
            );
        end
    endgenerate

    logic next_p, correct_p, wrong_p;
    assign next_p    = press[0];
    assign correct_p = press[1];
    assign wrong_p   = press[2];

    state_e                      state_q, state_d;
    logic [3:0]                  round_q, round_d;
    logic [1:0]                  player_q, player_d;
    digit_t [NUM_PLAYERS-1:0]    score_q, score_d;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= ST_IDLE;
            round_q  <= '0;
            player_q <= '0;
            score_q  <= '0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            player_q <= player_d;
            score_q  <= score_d;
        end
    end

    logic   any_win;
    logic   end_base;
    digit_t judged;

    always_comb begin
        any_win = 1'b0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            if (score_q[k] == WIN_D) any_win = 1'b1;
        end
        end_base = any_win || (round_q == MAX_R);
        judged   = correct_p ? bcd_inc_sat(score_q[player_q]) : bcd_dec_sat(score_q[player_q]);
    end

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        player_d = player_q;
        score_d  = score_q;
        case (state_q)
            ST_IDLE: begin
                if (next_p) begin
                    state_d = ST_ARMED;
                    round_d = round_q + 4'd1;
                end
            end
            ST_ARMED: begin
                if (Player_Number != '0) begin
                    state_d  = ST_JUDGE;
                    player_d = lowest_player(Player_Number);
                end else if (Time_Over) begin
                    state_d = ST_NOANS;
                end
            end
            ST_JUDGE: begin
                // Simultaneous Correct and Wrong cancel out.
                if (correct_p ^ wrong_p) begin
                    score_d[player_q] = judged;
                    state_d = (end_base || judged == WIN_D) ? ST_DONE : ST_IDLE;
                end
            end
            ST_NOANS: state_d = end_base ? ST_DONE : ST_IDLE;
            ST_DONE: begin
                if (next_p) begin
                    state_d = ST_IDLE;
                    round_d = '0;
                    score_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    digit_t                 max_score;
    logic [NUM_PLAYERS-1:0] win_mask;

    always_comb begin
        max_score = '0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            if (score_q[k] > max_score) max_score = score_q[k];
        end
        win_mask = '0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            win_mask[k] = (score_q[k] == max_score);
        end
    end

    assign Start_Out     = (state_q == ST_ARMED) || (state_q == ST_JUDGE);
    assign Game_Over_Out = (state_q == ST_DONE);
    assign Winner_Out    = Game_Over_Out ? win_mask : '0;
    assign Score_Out     = score_q;
    assign Round_Out     = round_q;

endmodule
